// File: rtl/ccr_unit.sv
// ccr_unit: condition-code register with branch-condition qualification and an interrupt flag-save LIFO
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   alu_flags[2:0]    ALU result flags {C,N,Z}
//   alu_flag_we[2:0]  per-flag write enables, same bit order
//   setc, clrc        force C to 1 / 0
//   branch_en         branch in decision stage
//   jump_type[1:0]    00 JZ, 01 JN, 10 JC, 11 JMP
//   jump_taken        jump decision feedback, clears the tested flag
//   int_save          push current flags
//   rti_restore       pop flags
//   flags[2:0]        registered {C,N,Z}
//   cond_flags[3:0]   qualified conditions {JMP,C,N,Z}
//   save_empty        no snapshots held
//   save_full         DEPTH snapshots held
//   save_err          sticky protocol error
module ccr_unit #(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] alu_flags,
    input  logic [2:0] alu_flag_we,
    input  logic       setc,
    input  logic       clrc,
    input  logic       branch_en,
    input  logic [1:0] jump_type,
    input  logic       jump_taken,
    input  logic       int_save,
    input  logic       rti_restore,
    output logic [2:0] flags,
    output logic [3:0] cond_flags,
    output logic       save_empty,
    output logic       save_full,
    output logic       save_err
);
    localparam int CW = $clog2(DEPTH + 1);
    // Index width kept at least 1 so DEPTH=1 still has a legal array index.
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [2:0]    stack [2**IW];
    logic [CW-1:0] count;
    logic [2:0]    clr, upd, flags_next;
    logic          c_next, conflict, do_push, do_pop, push_err, pop_err, sc_err;
    logic [IW-1:0] push_idx, pop_idx;

    assign save_empty = (count == '0);
    assign save_full  = (count == CW'(DEPTH));
    assign conflict   = int_save & rti_restore;
    assign do_push    = int_save & ~rti_restore & ~save_full;
    assign do_pop     = rti_restore & ~int_save & ~save_empty;
    assign push_err   = int_save & ~rti_restore & save_full;
    assign pop_err    = rti_restore & ~int_save & save_empty;
    assign sc_err     = setc & clrc;
    assign push_idx   = IW'(count);
    assign pop_idx    = IW'(count - CW'(1));

    assign cond_flags = branch_en ? {jump_type == 2'd3,
                                     (jump_type == 2'd2) & flags[2],
                                     (jump_type == 2'd1) & flags[1],
                                     (jump_type == 2'd0) & flags[0]} : 4'b0000;

    always_comb begin
        clr        = {3{branch_en & jump_taken}} &
                     {jump_type == 2'd2, jump_type == 2'd1, jump_type == 2'd0};
        upd        = (alu_flag_we & alu_flags) | (~alu_flag_we & ~clr & flags);
        c_next     = sc_err ? flags[2] : setc ? 1'b1 : clrc ? 1'b0 : upd[2];
        // A valid restore overrides every other update in the cycle.
        flags_next = do_pop ? stack[pop_idx] : {c_next, upd[1:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags    <= '0;
            count    <= '0;
            save_err <= 1'b0;
            for (int i = 0; i < 2**IW; i++) stack[i] <= '0;
        end else begin
            flags <= flags_next;
            if (do_push) begin
                stack[push_idx] <= flags;
                count           <= count + CW'(1);
            end else if (do_pop) begin
                count <= count - CW'(1);
            end
            if (sc_err | push_err | pop_err | conflict) save_err <= 1'b1;
        end
    end
endmodule

// File: doc/ccr_unit.md
# ccr_unit

Condition-code register and branch-condition generator for the processor pipeline. It holds the Z/N/C flags written by the ALU, produces the 4-bit qualified condition vector consumed by the jump decision unit, and clears the tested flag once a conditional jump is taken. It also keeps a small LIFO of flag snapshots so flags survive interrupt entry and are restored on RTI.

## Interface
- DEPTH, 2, number of interrupt save slots (nesting depth), ≥1
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- alu_flags  in  3  ALU result flags {C,N,Z} (bit0 Z, bit1 N, bit2 C)
- alu_flag_we  in  3  per-flag write enable, same bit order
- setc  in  1  SETC instruction: force C=1
- clrc  in  1  CLRC instruction: force C=0
- branch_en  in  1  branch instruction present in decision stage
- jump_type  in  2  00 JZ, 01 JN, 10 JC, 11 JMP (unconditional)
- jump_taken  in  1  jump decision feedback for the branch in decision stage
- int_save  in  1  interrupt entry: push current flags
- rti_restore  in  1  RTI: pop flags
- flags  out  3  registered {C,N,Z}
- cond_flags  out  4  qualified conditions to jump decision unit
- save_empty  out  1  no snapshots held
- save_full  out  1  DEPTH snapshots held
- save_err  out  1  sticky protocol error

## Operation
- cond_flags (combinational from the registered flags): bit0 = branch_en & type JZ & Z; bit1 = branch_en & type JN & N; bit2 = branch_en & type JC & C; bit3 = branch_en & type JMP. At most one bit is set. All bits are 0 when branch_en=0.
- Flag next-state, per flag, highest priority first:
  1. Valid rti_restore: the popped snapshot replaces all three flags. Every other update in that cycle is ignored.
  2. C only: setc/clrc. If both are asserted, C holds and save_err is set.
  3. alu_flag_we[i]: flag i takes alu_flags[i].
  4. Jump clear: branch_en & jump_taken & type JZ/JN/JC clears the tested flag (Z/N/C respectively). JMP clears nothing.
  5. Otherwise the flag holds.
- Snapshot LIFO: DEPTH×3-bit array plus a count of 0..DEPTH.
  - int_save pushes the pre-update flags, i.e. the value before this edge's updates. Updates in the same cycle still apply to the live flags.
  - rti_restore pops the most recent snapshot.
- Error cases:
  - push when full: dropped, count unchanged, save_err=1.
  - pop when empty: ignored, flags follow the normal priority, save_err=1.
  - int_save & rti_restore in the same cycle: both ignored, save_err=1, flags follow the normal priority excluding restore.
- save_err is sticky until reset.
- save_empty = (count==0); save_full = (count==DEPTH). Both are registered-derived.

## Timing
- Reset (async assert, sync release via clk): flags=000, count=0, save_empty=1, save_full=0, save_err=0, cond_flags=0000.
- cond_flags responds to branch_en/jump_type in the same cycle (zero latency). It reflects flags as of the last edge.
- Flag, LIFO, and status updates take effect at the rising edge and are visible in the next cycle. Latency is 1 cycle.
- An ALU write and a branch test in the same cycle: the branch sees the old flag, and the ALU value lands at the edge.
- The jump clear happens at the same edge on which the jump is taken. A second JZ issued in the next cycle sees Z=0.
- Reset asserted mid-operation drops all snapshots immediately, with no drain.

## Test plan
- Reset then idle: flags=000, cond_flags=0000, save_empty=1, save_err=0.
- alu_flag_we=001, alu_flags=001. Next cycle: branch_en=1, type JZ → cond_flags=0001. Assert jump_taken → next cycle Z=0 and cond_flags=0000.
- Set Z via ALU. In the same cycle as a taken JZ, alu writes Z=1 → Z=1 after the edge (ALU wins). Also: setc and clrc together → C unchanged, save_err=1.
- flags=101, int_save; ALU writes 010; int_save again; rti_restore twice → flags 010 then 101, save_empty=1, no error.
- DEPTH=2: three pushes → third dropped, save_full=1, save_err=1. Then three pops → third pop ignored, flags unchanged.
- Fill one snapshot, assert rst_n=0 between edges → outputs go to reset values immediately, and count=0 after release.
